// File: rtl/search_arbiter.sv
// Two-requester front end for a shared binary-search engine: round-robin
// arbitration, launch/watchdog/abort sequencing and per-owner result routing.
module search_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic              found,
  output logic [ADDR_W-1:0] f_addr,
  output logic              timeout,
  output logic              busy,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_A,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic              eng_found,
  input  logic [ADDR_W-1:0] eng_addr
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ABORT,
    S_REPORT
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q,  last_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [DATA_W-1:0]   tgt_q,   tgt_d;
  logic                found_q, found_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic                tout_q,  tout_d;
  logic                grant0_q, grant0_d;
  logic                grant1_q, grant1_d;
  logic                done0_q,  done0_d;
  logic                done1_q,  done1_d;
  logic                busy_q,   busy_d;
  logic                start_q,  start_d;
  logic                abort_q,  abort_d;

  // State and all registered outputs; last_q resets to 1 so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      tgt_q    <= '0;
      found_q  <= 1'b0;
      faddr_q  <= '0;
      tout_q   <= 1'b0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      found_q  <= found_d;
      faddr_q  <= faddr_d;
      tout_q   <= tout_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // With both pending, serve whoever was not served last.
          owner_d = (req0 && req1) ? ~last_q : req1;
          tgt_d   = owner_d ? a1 : a0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d = S_REPORT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ABORT: begin
        state_d = S_REPORT;
      end
      S_REPORT: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in-state.
  always_comb begin
    grant0_d = (state_d == S_LAUNCH) && !owner_d;
    grant1_d = (state_d == S_LAUNCH) &&  owner_d;
    done0_d  = (state_d == S_REPORT) && !owner_d;
    done1_d  = (state_d == S_REPORT) &&  owner_d;
    start_d  = (state_d == S_LAUNCH);
    abort_d  = (state_d == S_ABORT);
    busy_d   = (state_d != S_IDLE);
    found_d  = found_q;
    faddr_d  = faddr_q;
    tout_d   = tout_q;
    if (state_q == S_WAIT && eng_done) begin
      found_d = eng_found;
      faddr_d = eng_found ? eng_addr : '0;
      tout_d  = 1'b0;
    end else if (state_q == S_ABORT) begin
      found_d = 1'b0;
      faddr_d = '0;
      tout_d  = 1'b1;
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign found     = found_q;
  assign f_addr    = faddr_q;
  assign timeout   = tout_q;
  assign busy      = busy_q;
  assign eng_start = start_q;
  assign eng_A     = tgt_q;
  assign eng_abort = abort_q;

endmodule

// File: tb/tb_search_arbiter.sv
// Directed plus randomized bench for search_arbiter with a transaction-level
// model of arbitration order, launch/abort timing and result routing.
module tb_search_arbiter;

  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, a1 = '0;
  logic       grant0, grant1, done0, done1, found, timeout, busy;
  logic       eng_start, eng_abort;
  logic [4:0] f_addr;
  logic [7:0] eng_A;
  logic       eng_done = 1'b0, eng_found = 1'b0;
  logic [4:0] eng_addr = '0;

  int n_checks = 0;
  int n_err    = 0;
  bit m_last   = 1'b1;

  search_arbiter #(.DATA_W(8), .ADDR_W(5), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .found(found), .f_addr(f_addr), .timeout(timeout), .busy(busy),
    .eng_start(eng_start), .eng_A(eng_A), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_found(eng_found), .eng_addr(eng_addr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant0"}, grant0, 0);
    chk({tag, "_grant1"}, grant1, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_faddr"}, f_addr, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, eng_start, 0);
    chk({tag, "_abort"}, eng_abort, 0);
    chk({tag, "_engA"}, eng_A, 0);
  endtask

  // One complete search from the IDLE cycle to the following IDLE cycle.
  // lat = index of the WAIT cycle where the engine reports done; lat >= T means never.
  task automatic run_txn(input bit n0, input bit n1, input logic [7:0] t0,
                         input logic [7:0] t1, input int lat, input bit ef,
                         input logic [4:0] ea, input bit hold, output bit got_owner);
    bit         own;
    logic [7:0] tgt;
    bit         exp_t, exp_f;
    logic [4:0] exp_a;
    if (n0 && !req0) begin req0 = 1'b1; a0 = t0; end
    if (n1 && !req1) begin req1 = 1'b1; a1 = t1; end
    chk("idle_busy", busy, 0);
    own = (req0 && req1) ? !m_last : req1;
    tgt = own ? a1 : a0;
    step();
    got_owner = grant1;
    chk("launch_grant0", grant0, !own);
    chk("launch_grant1", grant1, own);
    chk("launch_start", eng_start, 1);
    chk("launch_abort", eng_abort, 0);
    chk("launch_engA", eng_A, tgt);
    chk("launch_busy", busy, 1);
    chk("launch_done", {done0, done1}, 0);
    if (!hold) begin
      if (own) req1 = 1'b0; else req0 = 1'b0;
    end
    eng_done  = 1'($urandom_range(0, 1));
    eng_found = 1'b1;
    eng_addr  = 5'($urandom);
    step();
    for (int j = 0; j < T; j++) begin
      eng_done  = (j == lat);
      eng_found = ef;
      eng_addr  = ea;
      chk("wait_grant", {grant0, grant1}, 0);
      chk("wait_start", eng_start, 0);
      chk("wait_abort", eng_abort, 0);
      chk("wait_done", {done0, done1}, 0);
      chk("wait_busy", busy, 1);
      chk("wait_engA", eng_A, tgt);
      step();
      if (j == lat) break;
    end
    if (lat >= T) begin
      eng_done  = 1'b1;
      eng_found = 1'b1;
      chk("abort_pulse", eng_abort, 1);
      chk("abort_done", {done0, done1}, 0);
      chk("abort_busy", busy, 1);
      step();
    end
    eng_done  = 1'($urandom_range(0, 1));
    eng_found = 1'b1;
    exp_t = (lat >= T);
    exp_f = !exp_t && ef;
    exp_a = exp_f ? ea : 5'd0;
    chk("report_done0", done0, !own);
    chk("report_done1", done1, own);
    chk("report_found", found, exp_f);
    chk("report_faddr", f_addr, exp_a);
    chk("report_timeout", timeout, exp_t);
    chk("report_abort", eng_abort, 0);
    chk("report_grant", {grant0, grant1}, 0);
    chk("report_engA", eng_A, tgt);
    m_last = own;
    step();
    eng_done  = 1'b0;
    eng_found = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_done", {done0, done1}, 0);
    chk("post_found_hold", found, exp_f);
    chk("post_faddr_hold", f_addr, exp_a);
  endtask

  initial begin
    bit own;
    bit n0, n1;

    // Reset state
    step(); step();
    chk_all_zero("rst");
    reset = 1'b0;
    step();
    chk_all_zero("rst_rel");

    // Single request, found
    run_txn(1, 0, 8'h3C, 8'h00, 5, 1, 5'd17, 0, own);
    chk("single_owner", own, 0);

    // Not found on requester 1; req1 dropped after capture
    run_txn(0, 1, 8'h00, 8'h77, 2, 0, 5'd9, 0, own);
    chk("nf_owner", own, 1);

    // Watchdog expiry, then a normal search
    run_txn(1, 0, 8'hA5, 8'h00, T + 3, 1, 5'd4, 0, own);
    run_txn(0, 1, 8'h00, 8'h42, 0, 1, 5'd31, 0, own);

    // Engine done exactly on the last watchdog cycle
    run_txn(1, 0, 8'h99, 8'h00, T - 1, 1, 5'd29, 0, own);

    // Reset in the middle of WAIT
    req0 = 1'b1; a0 = 8'h55;
    step();
    chk("rm_grant0", grant0, 1);
    req0 = 1'b0;
    step(); step();
    chk("rm_busy", busy, 1);
    reset = 1'b1;
    step();
    chk_all_zero("rm");
    reset = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_idle_done", {done0, done1}, 0);
      chk("rm_idle_busy", busy, 0);
    end

    // Contention from reset: both held, order 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 8'h10, 8'h20, 3, 1, 5'(i + 1), (i < 3), own);
      chk("rr_order", own, i % 2);
    end
    run_txn(0, 0, 8'h00, 8'h00, 1, 1, 5'd7, 0, own);
    chk("rr_pending", own, 0);

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      n0 = 1'($urandom_range(0, 1));
      n1 = 1'($urandom_range(0, 1));
      if (!n0 && !n1 && !req0 && !req1) n0 = 1'b1;
      run_txn(n0, n1, 8'($urandom), 8'($urandom), int'($urandom_range(0, T + 1)),
              1'($urandom_range(0, 1)), 5'($urandom), 0, own);
    end
    while (req0 || req1) begin
      run_txn(0, 0, 8'h00, 8'h00, 2, 1, 5'd3, 0, own);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
